// File: rtl/data_mem_resp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : data_mem_resp_pkg
// Brief   : Shared FSM state, data width and LED MMIO address constants.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package data_mem_resp_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] LED_LO_ADDR = 8'hFE;
  localparam logic [7:0] LED_HI_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_resp_dmem_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : dmem_array
// Brief   : DEPTH x 8 data store, synchronous write, combinational read.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_array
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [7:0]        i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int         c_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] c_depth = 9'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]   w_idx;
  logic              w_hit;

  assign w_idx = i_addr[c_aw-1:0];
  // Range test keeps truncated indices from aliasing onto real words.
  assign w_hit = ({1'b0, i_addr} < c_depth);

  always_ff @(posedge clk) begin
    if (i_we && w_hit) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

  assign o_rdata = w_hit ? r_mem[w_idx] : '0;

endmodule
`default_nettype wire

// File: rtl/data_mem_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : data_mem_resp
// Brief   : Wait-state data memory responder; optional LED MMIO (LED_MMIO_EN).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [7:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [15:0]       led
);

  localparam logic [8:0] c_depth     = 9'(DEPTH);
  localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_cap_err;
  logic [DATA_W-1:0] r_cap_rdata;

  logic              w_accept;
  logic              w_in_range;
  logic              w_mem_we;
  logic              w_err;
  logic [DATA_W-1:0] w_mem_rdata;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_cap_rdata;

  assign w_accept   = req_valid & r_ready;
  assign w_in_range = ({1'b0, req_addr} < c_depth);

`ifdef LED_MMIO_EN
  logic [15:0] r_led;
  logic        w_led_lo;
  logic        w_led_hi;

  assign w_led_lo  = (req_addr == LED_LO_ADDR);
  assign w_led_hi  = (req_addr == LED_HI_ADDR);
  assign w_mem_we  = w_accept & req_wr & w_in_range & ~(w_led_lo | w_led_hi);
  assign w_rd_data = w_led_lo ? r_led[7:0] : (w_led_hi ? r_led[15:8] : w_mem_rdata);
  assign w_err     = ~(w_in_range | w_led_lo | w_led_hi);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= '0;
    end else if (w_accept && req_wr) begin
      if (w_led_lo) r_led[7:0]  <= req_wdata;
      if (w_led_hi) r_led[15:8] <= req_wdata;
    end
  end

  assign led = r_led;
`else
  assign w_mem_we  = w_accept & req_wr & w_in_range;
  assign w_rd_data = w_mem_rdata;
  assign w_err     = ~w_in_range;
  assign led       = 16'h0000;
`endif

  // Writes acknowledge with zero data; reads carry the word seen at acceptance.
  assign w_cap_rdata = req_wr ? '0 : w_rd_data;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (req_addr),
    .i_wdata (req_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cap_rdata <= '0;
      r_cap_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready     <= 1'b0;
            r_cap_rdata <= w_cap_rdata;
            r_cap_err   <= w_err;
            if (WAIT_CYCLES == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_cap_rdata;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_wait_load;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_cap_rdata;
            r_rsp_err   <= r_cap_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
